// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : osc_pkg
// Description : Shared definitions for the acquisition front end: default
//               sample width and frame depth, the capture state encoding and
//               the sample type.
// Revision    : 1.0 - initial release
// ============================================================================
package osc_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_DEPTH = 512;

    typedef logic [DEF_WIDTH-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST_FILL = 3'd3,
        UNROLL    = 3'd4,
        HANDOFF   = 3'd5,
        WAIT_ACK  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/trigger_detect.sv
`default_nettype none
// ============================================================================
// Module      : trigger_detect
// Description : Level-crossing detector. Holds the previously accepted sample
//               and the threshold/edge selection latched at arm time, and
//               compares the incoming sample against them combinationally.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               load             - latch level/falling (arm or re-arm)
//               level, falling   - threshold and edge select to latch
//               accept           - current sample is taken into the ring
//               sample_valid     - sample qualifier
//               sample           - incoming ADC sample
//               trig             - crossing detected on this valid sample
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_detect
    import osc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] level,
    input  logic             falling,
    input  logic             accept,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             trig
);

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_level;
    logic             r_falling;
    logic             w_rise;
    logic             w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_level   <= '0;
            r_falling <= 1'b0;
        end else begin
            if (load) begin
                r_level   <= level;
                r_falling <= falling;
            end
            // prev tracks only samples that were written to the ring, so the
            // first WAIT_TRIG compare sees the last pre-trigger sample.
            if (accept) begin
                r_prev <= sample;
            end
        end
    end

    assign w_rise = (r_prev < r_level) && (sample >= r_level);
    assign w_fall = (r_prev > r_level) && (sample <= r_level);
    assign trig   = sample_valid && (r_falling ? w_fall : w_rise);

endmodule
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture
// Description : Records ADC samples into a ring buffer with a programmable
//               pre-trigger history, waits for a level crossing (or a forced
//               trigger on timeout in auto mode), fills the post-trigger part,
//               unrolls the ring into a linear frame with the trigger sample
//               at index PRE, then hands the frame to the copier.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               sample_valid     - sample qualifier
//               sample           - ADC sample
//               trig_level       - trigger threshold (latched on arm)
//               trig_falling     - 0 rising / 1 falling (latched on arm)
//               auto_mode        - forced trigger on timeout (latched on arm)
//               cont             - re-arm automatically after handoff
//               arm              - start a capture (IDLE only)
//               copier_ready     - ready from the frame copier
//               frame_read       - one-cycle start pulse to the copier
//               frame            - linear frame, written only while unrolling
//               busy             - any state other than IDLE
//               forced           - last frame came from a timeout
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture
    import osc_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PRE     = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_falling,
    input  logic             auto_mode,
    input  logic             cont,
    input  logic             arm,
    input  logic             copier_ready,
    output logic             frame_read,
    output logic [WIDTH-1:0] frame [0:DEPTH-1],
    output logic             busy,
    output logic             forced
);

    localparam int               c_aw       = $clog2(DEPTH);
    localparam int               c_tw       = $clog2(TIMEOUT + 1);
    localparam logic [c_aw-1:0]  c_pre      = c_aw'(PRE);
    localparam logic [c_aw-1:0]  c_pre_last = c_aw'(PRE - 1);
    localparam logic [c_aw-1:0]  c_post_m1  = c_aw'(DEPTH - PRE - 1);
    localparam logic [c_aw-1:0]  c_last     = c_aw'(DEPTH - 1);
    localparam logic [c_aw-1:0]  c_one      = c_aw'(1);
    localparam logic [c_tw-1:0]  c_tmo      = c_tw'(TIMEOUT);

    state_t            r_state;
    logic [c_aw-1:0]   r_wptr;
    logic [c_aw-1:0]   r_cnt;
    logic [c_tw-1:0]   r_tmo;
    logic [c_aw-1:0]   r_start;
    logic [c_aw-1:0]   r_uidx;
    logic              r_auto;
    logic              r_ack_low;
    logic              r_frame_read;
    logic              r_busy;
    logic              r_forced;

    logic [WIDTH-1:0]  r_ring [0:DEPTH-1];

    logic              w_capturing;
    logic              w_accept;
    logic              w_edge;
    logic              w_force;
    logic              w_trig_any;
    logic              w_rearm;
    logic              w_load;
    logic [c_aw-1:0]   w_rd_addr;

    assign w_capturing = (r_state == PRE_FILL) || (r_state == WAIT_TRIG) ||
                         (r_state == POST_FILL);
    assign w_accept    = sample_valid && w_capturing;

    // Re-arm from WAIT_ACK happens once ready has gone low and come back high.
    assign w_rearm     = (r_state == WAIT_ACK) && copier_ready && r_ack_low && cont;
    assign w_load      = ((r_state == IDLE) && arm) || w_rearm;

    // The timeout sample itself becomes the trigger once TIMEOUT samples have
    // passed in WAIT_TRIG without a crossing.
    assign w_force     = r_auto && (r_tmo == c_tmo) && sample_valid;
    assign w_trig_any  = w_edge || w_force;

    assign w_rd_addr   = r_start + r_uidx;

    trigger_detect #(
        .WIDTH (WIDTH)
    ) u_trigger_detect (
        .clk          (clk),
        .rst          (rst),
        .load         (w_load),
        .level        (trig_level),
        .falling      (trig_falling),
        .accept       (w_accept),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig         (w_edge)
    );

    // Ring storage: no reset so it maps onto memory.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_ring[r_wptr] <= sample;
        end
    end

    // Frame is only ever written while unrolling, so it holds still during
    // the whole copy.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == UNROLL)) begin
            frame[r_uidx] <= r_ring[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_start      <= '0;
            r_uidx       <= '0;
            r_auto       <= 1'b0;
            r_ack_low    <= 1'b0;
            r_frame_read <= 1'b0;
            r_busy       <= 1'b0;
            r_forced     <= 1'b0;
        end else begin
            r_frame_read <= 1'b0;
            if (w_accept) begin
                r_wptr <= r_wptr + c_one;
            end

            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_state  <= PRE_FILL;
                        r_wptr   <= '0;
                        r_cnt    <= '0;
                        r_tmo    <= '0;
                        r_auto   <= auto_mode;
                        r_forced <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                PRE_FILL: begin
                    if (sample_valid) begin
                        if (r_cnt == c_pre_last) begin
                            r_cnt   <= '0;
                            r_state <= WAIT_TRIG;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end

                WAIT_TRIG: begin
                    if (w_trig_any) begin
                        // The frame starts PRE entries before the trigger
                        // address; modulo arithmetic handles the wrap.
                        r_start  <= r_wptr - c_pre;
                        r_forced <= !w_edge;
                        r_cnt    <= c_one;
                        r_state  <= (c_post_m1 == '0) ? UNROLL : POST_FILL;
                    end else if (sample_valid && (r_tmo != c_tmo)) begin
                        r_tmo <= r_tmo + c_tw'(1);
                    end
                end

                POST_FILL: begin
                    if (sample_valid) begin
                        if (r_cnt == c_post_m1) begin
                            r_state <= UNROLL;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end

                UNROLL: begin
                    // Index wraps back to zero after the last entry.
                    r_uidx <= r_uidx + c_one;
                    if (r_uidx == c_last) begin
                        r_state <= HANDOFF;
                    end
                end

                HANDOFF: begin
                    if (copier_ready) begin
                        r_frame_read <= 1'b1;
                        r_ack_low    <= 1'b0;
                        r_state      <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (!copier_ready) begin
                        r_ack_low <= 1'b1;
                    end else if (r_ack_low) begin
                        if (cont) begin
                            r_state <= PRE_FILL;
                            r_wptr  <= '0;
                            r_cnt   <= '0;
                            r_tmo   <= '0;
                            r_auto  <= auto_mode;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_read = r_frame_read;
    assign busy       = r_busy;
    assign forced     = r_forced;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_capture
// Description : Self-checking bench for trigger_capture. A reference model
//               keeps the list of samples the capture should accept, finds
//               the trigger from the crossing/timeout rules and predicts the
//               frame as the DEPTH consecutive accepted samples around it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int WIDTH   = 12;
    localparam int DEPTH   = 512;
    localparam int PRE     = 128;
    localparam int TIMEOUT = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] sample = '0;
    logic [WIDTH-1:0] trig_level = '0;
    logic             trig_falling = 1'b0;
    logic             auto_mode = 1'b0;
    logic             cont = 1'b0;
    logic             arm = 1'b0;
    logic             copier_ready = 1'b1;
    logic             frame_read;
    logic [WIDTH-1:0] frame [0:DEPTH-1];
    logic             busy;
    logic             forced;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int acc[$];
    int trig_idx;
    int glev;
    bit gfall;
    bit gauto;
    bit exp_forced;

    trigger_capture #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PRE     (PRE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .auto_mode    (auto_mode),
        .cont         (cont),
        .arm          (arm),
        .copier_ready (copier_ready),
        .frame_read   (frame_read),
        .frame        (frame),
        .busy         (busy),
        .forced       (forced)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_junk();
        sample       = WIDTH'($urandom_range(0, 4095));
        sample_valid = 1'($urandom_range(0, 1));
        arm          = 1'b0;
    endtask

    task automatic do_arm(input int lev, input bit fall, input bit au);
        glev = lev; gfall = fall; gauto = au; exp_forced = 1'b0;
        trig_level = WIDTH'(lev); trig_falling = fall; auto_mode = au;
        arm = 1'b1; sample_valid = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
        check_eq("busy_after_arm", busy, 1'b1);
        check_eq("forced_cleared", forced, 1'b0);
    endtask

    // Drives one capture. mode: 0 ramp up, 1 ramp down, 2 constant 500,
    // 3 low noise then a late ramp above the level, 4 uniform random.
    task automatic run_capture(input int mode, input int pct, input int abort_post, output bit done);
        int t;
        int v;
        int k;
        bit val;
        bit tr;
        acc.delete();
        trig_idx = -1;
        done = 1'b0;
        t = 0;
        while (t < 20000) begin
            case (mode)
                0: v = t % 4096;
                1: v = 4095 - (t % 4096);
                2: v = 500;
                3: v = (acc.size() < PRE + 1000) ? int'($urandom_range(0, glev - 1))
                                                 : glev + ((acc.size() - PRE - 1000) % 1000);
                default: v = int'($urandom_range(0, 4095));
            endcase
            val = (int'($urandom_range(1, 100)) <= pct);
            sample = WIDTH'(v);
            sample_valid = val;
            // Mid-capture changes must be ignored until the next arm.
            arm = 1'($urandom_range(0, 1));
            trig_level = WIDTH'($urandom_range(0, 4095));
            trig_falling = 1'($urandom_range(0, 1));
            auto_mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (val) begin
                acc.push_back(v);
                k = acc.size() - 1;
                if (trig_idx < 0 && k >= PRE) begin
                    if (gfall) tr = (acc[k-1] > glev) && (acc[k] <= glev);
                    else       tr = (acc[k-1] < glev) && (acc[k] >= glev);
                    if (tr) exp_forced = 1'b0;
                    else if (gauto && (k - PRE) == TIMEOUT) begin
                        tr = 1'b1;
                        exp_forced = 1'b1;
                    end
                    if (tr) trig_idx = k;
                end
                if (trig_idx >= 0) begin
                    if (abort_post > 0 && (k - trig_idx + 1) == abort_post) return;
                    if ((k - trig_idx + 1) == DEPTH - PRE) begin
                        done = 1'b1;
                        return;
                    end
                end
            end
            t++;
        end
        check_eq("capture_done", done, 1'b1);
    endtask

    task automatic wait_frame(output bit got);
        int n;
        n = 0;
        got = 1'b0;
        while (n < 3 * DEPTH) begin
            drive_junk();
            @(posedge clk); #1;
            n++;
            if (frame_read) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("frame_read_latency", n, DEPTH + 1);
    endtask

    task automatic check_frame();
        int nbad;
        logic [WIDTH-1:0] e;
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e = WIDTH'(acc[trig_idx - PRE + i]);
            if (frame[i] !== e) nbad++;
        end
        check_eq("frame_mismatches", nbad, 0);
        check_eq("forced_flag", forced, exp_forced);
    endtask

    task automatic handoff(input int low, input bit contv);
        int bad;
        bad = 0;
        cont = contv;
        drive_junk();
        @(posedge clk); #1;
        check_eq("frame_read_pulse", frame_read, 1'b0);
        copier_ready = 1'b0;
        for (int i = 0; i < low; i++) begin
            drive_junk();
            @(posedge clk); #1;
            if (frame_read || !busy) bad++;
        end
        check_eq("ack_hold", bad, 0);
        copier_ready = 1'b1;
        trig_level = WIDTH'(glev); trig_falling = gfall; auto_mode = gauto;
        drive_junk();
        sample_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("busy_after_ack", busy, contv);
    endtask

    task automatic capture_and_handoff(input int mode, input int pct, input int low, input bit contv);
        bit done;
        bit got;
        run_capture(mode, pct, 0, done);
        if (!done) return;
        wait_frame(got);
        if (!got) return;
        check_frame();
        handoff(low, contv);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; arm = 1'b0;
        drive_junk();
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_read", frame_read, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int bad;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_frame_read", frame_read, 1'b0);
        check_eq("reset_forced", forced, 1'b0);

        // Rising ramp
        do_arm(1000, 1'b0, 1'b0);
        capture_and_handoff(0, 100, 3, 1'b0);
        check_eq("rise_f128", frame[128], 1000);
        check_eq("rise_f0", frame[0], 872);
        check_eq("rise_f511", frame[511], 1383);

        // Falling ramp
        do_arm(2000, 1'b1, 1'b0);
        capture_and_handoff(1, 100, 3, 1'b0);
        check_eq("fall_f128", frame[128], 2000);
        check_eq("fall_f127", frame[127], 2001);

        // Auto timeout on a flat signal
        do_arm(1000, 1'b0, 1'b1);
        capture_and_handoff(2, 100, 3, 1'b0);
        check_eq("auto_forced", forced, 1'b1);
        check_eq("auto_f300", frame[300], 500);

        // No auto: capture must stall in WAIT_TRIG
        do_arm(1000, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < PRE + TIMEOUT + 300; i++) begin
            sample = 12'd500; sample_valid = 1'b1; arm = 1'b0;
            @(posedge clk); #1;
            if (frame_read || !busy) bad++;
        end
        check_eq("noauto_stall", bad, 0);
        pulse_reset();

        // Sparse valid, late trigger after the write pointer has wrapped
        do_arm(3000, 1'b0, 1'b0);
        capture_and_handoff(3, 33, 5, 1'b0);
        check_eq("gap_f128", frame[128], 3000);

        // Reset in the middle of POST_FILL
        do_arm(1000, 1'b0, 1'b0);
        run_capture(0, 100, 50, done);
        pulse_reset();
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            drive_junk();
            @(posedge clk); #1;
            if (frame_read || busy) bad++;
        end
        check_eq("post_reset_quiet", bad, 0);
        do_arm(1000, 1'b0, 1'b0);
        capture_and_handoff(0, 100, 3, 1'b0);

        // Slow copier, continuous mode re-arms exactly after ready returns
        do_arm(1000, 1'b0, 1'b0);
        capture_and_handoff(0, 100, 600, 1'b1);
        capture_and_handoff(0, 100, 4, 1'b0);
        check_eq("cont_f0", frame[0], 872);

        // Random captures
        for (int r = 0; r < 3; r++) begin
            do_arm(int'($urandom_range(100, 3995)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            capture_and_handoff(4, int'($urandom_range(30, 100)), int'($urandom_range(1, 20)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
